// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed 7-segment scan controller:
// segment code table, dark constant, decode helper and blink phase type.
package seg_pkg;

  localparam int TICK_W = 24;
  localparam int SEG_W  = 7;

  localparam logic [SEG_W-1:0] SEG_DARK = 7'b0000000;

  // Segment order is {a,b,c,d,e,f,g}; codes 10..15 have no glyph and stay dark.
  localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1110011, SEG_DARK,   SEG_DARK,
    SEG_DARK,   SEG_DARK,   SEG_DARK,   SEG_DARK
  };

  typedef enum logic {
    PHASE_ON  = 1'b0,
    PHASE_OFF = 1'b1
  } blink_phase_e;

  function automatic logic [SEG_W-1:0] segDecode(input logic [3:0] code);
    return SEG_TABLE[code];
  endfunction

endpackage

// File: rtl/seg_tick_gen.sv
// Divides the system clock into digit slots: tick_o is high for one cycle
// every SCAN_DIV cycles, on the cycle the counter sits at SCAN_DIV-1.
module seg_tick_gen
  import seg_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_o
);

  localparam logic [TICK_W-1:0] LAST = TICK_W'(SCAN_DIV - 1);

  logic [TICK_W-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = tick_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment display scanner: steps one digit per slot tick,
// freezes inputs per frame in a shadow register, and applies blank/blink/LZS.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIG     = 6,
  parameter int SCAN_DIV    = 50000,
  parameter int BLINK_FRM   = 64,
  parameter int ENB_ACT_LOW = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [4*NUM_DIG-1:0]   i_bcd,
  input  logic [NUM_DIG-1:0]     i_dp,
  input  logic [NUM_DIG-1:0]     i_blank,
  input  logic [NUM_DIG-1:0]     i_blink,
  input  logic                   i_lzs,
  output logic [SEG_W-1:0]       o_seg,
  output logic                   o_seg_dp,
  output logic [NUM_DIG-1:0]     o_seg_enb,
  output logic                   o_frame
);

  localparam int                IDX_W    = $clog2(NUM_DIG);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_DIG - 1);
  localparam logic [7:0]        LAST_BLK = 8'(BLINK_FRM - 1);

  logic                 tick;
  logic                 wrap;
  logic [IDX_W-1:0]     idx_q, idx_d;

  logic [4*NUM_DIG-1:0] shBcd_q, shBcd_d;
  logic [NUM_DIG-1:0]   shDp_q, shDp_d;
  logic [NUM_DIG-1:0]   shBlank_q, shBlank_d;
  logic [NUM_DIG-1:0]   shBlink_q, shBlink_d;
  logic                 shLzs_q, shLzs_d;

  logic [7:0]           blkCnt_q, blkCnt_d;
  blink_phase_e         phase_q, phase_d;

  logic [SEG_W-1:0]     seg_q, seg_d;
  logic                 dp_q, dp_d;
  logic [NUM_DIG-1:0]   enb_q, enb_d;
  logic                 frame_q, frame_d;

  logic [3:0]           selCode;
  logic                 selDp, selBlank, selBlink, selZeroRun, dark;

  seg_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick_o (tick)
  );

  assign wrap = tick && (idx_q == LAST_IDX);

  always_comb begin
    idx_d     = idx_q;
    shBcd_d   = shBcd_q;
    shDp_d    = shDp_q;
    shBlank_d = shBlank_q;
    shBlink_d = shBlink_q;
    shLzs_d   = shLzs_q;
    blkCnt_d  = blkCnt_q;
    phase_d   = phase_q;
    if (tick) begin
      idx_d = wrap ? '0 : idx_q + 1'b1;
    end
    // Inputs and blink phase only move at the frame boundary so a frame is always coherent.
    if (wrap) begin
      shBcd_d   = i_bcd;
      shDp_d    = i_dp;
      shBlank_d = i_blank;
      shBlink_d = i_blink;
      shLzs_d   = i_lzs;
      if (blkCnt_q == LAST_BLK) begin
        blkCnt_d = '0;
        phase_d  = (phase_q == PHASE_ON) ? PHASE_OFF : PHASE_ON;
      end else begin
        blkCnt_d = blkCnt_q + 8'd1;
      end
    end
  end

  always_comb begin
    selCode    = '0;
    selDp      = 1'b0;
    selBlank   = 1'b0;
    selBlink   = 1'b0;
    selZeroRun = 1'b0;
    for (int k = 0; k < NUM_DIG; k++) begin
      if (idx_q == IDX_W'(k)) begin
        selCode    = shBcd_q[4*k +: 4];
        selDp      = shDp_q[k];
        selBlank   = shBlank_q[k];
        selBlink   = shBlink_q[k];
        selZeroRun = 1'b1;
        for (int j = 0; j < NUM_DIG; j++) begin
          if (j >= k && shBcd_q[4*j +: 4] != 4'd0) begin
            selZeroRun = 1'b0;
          end
        end
      end
    end
    dark = selBlank
         || (selBlink && phase_q == PHASE_OFF)
         || (shLzs_q && idx_q != '0 && selZeroRun);
  end

  always_comb begin
    seg_d   = seg_q;
    dp_d    = dp_q;
    enb_d   = enb_q;
    frame_d = wrap;
    // Bring up digit 0's enable right after reset so exactly one digit is always driven.
    if (enb_q == '0) begin
      enb_d = NUM_DIG'(1);
    end
    if (tick) begin
      seg_d = dark ? SEG_DARK : segDecode(selCode);
      dp_d  = selDp && !dark;
      enb_d = NUM_DIG'(1) << idx_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      shBcd_q   <= '0;
      shDp_q    <= '0;
      shBlank_q <= '0;
      shBlink_q <= '0;
      shLzs_q   <= 1'b0;
      blkCnt_q  <= '0;
      phase_q   <= PHASE_ON;
      seg_q     <= SEG_DARK;
      dp_q      <= 1'b0;
      enb_q     <= '0;
      frame_q   <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      shBcd_q   <= shBcd_d;
      shDp_q    <= shDp_d;
      shBlank_q <= shBlank_d;
      shBlink_q <= shBlink_d;
      shLzs_q   <= shLzs_d;
      blkCnt_q  <= blkCnt_d;
      phase_q   <= phase_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      enb_q     <= enb_d;
      frame_q   <= frame_d;
    end
  end

  assign o_seg     = seg_q;
  assign o_seg_dp  = dp_q;
  assign o_seg_enb = (ENB_ACT_LOW != 0) ? ~enb_q : enb_q;
  assign o_frame   = frame_q;

endmodule
